// File: rtl/mem_arb.sv
// mem_arb: two-port round-robin arbiter sharing one single-port RAM, one access in flight
module mem_arb #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic last, id, we_q, any_req, win, take;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  assign any_req = p0_req | p1_req;
  assign win = (p0_req & p1_req) ? ~last : p1_req;
  assign take = (state == IDLE) & any_req;
  // state register; async reset also aborts any access in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // capture the winning request and remember it for the next tie
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last    <= 1'b1;
      id      <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (take) begin
      last    <= win;
      id      <= win;
      we_q    <= win ? p1_we : p0_we;
      addr_q  <= win ? p1_addr : p0_addr;
      wdata_q <= win ? p1_wdata : p0_wdata;
    end
  // next state and all outputs decoded from the current state
  always_comb begin
    state_nx  = (state == IDLE) ? (any_req ? ACCESS : IDLE) : (state == ACCESS) ? DONE : IDLE;
    busy      = state != IDLE;
    ram_en    = state == ACCESS;
    ram_we    = ram_en & we_q;
    ram_addr  = ram_en ? addr_q : '0;
    ram_wdata = ram_en ? wdata_q : '0;
    p0_ack    = (state == DONE) & ~id;
    p1_ack    = (state == DONE) & id;
    p0_rdata  = (p0_ack & ~we_q) ? ram_rdata : '0;
    p1_rdata  = (p1_ack & ~we_q) ? ram_rdata : '0;
  end
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed self-checking bench for mem_arb with a behavioural RAM
module tb_mem_arb;
  localparam int AW = 6;
  localparam int DW = 32;
  logic clk = 0, rst_n = 0;
  logic p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic p0_ack, p1_ack, ram_en, ram_we, busy;
  logic [DW-1:0] p0_rdata, p1_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int n_chk = 0, n_fail = 0;

  mem_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // synchronous single-port RAM with registered read
  always @(posedge clk)
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_chk++; if ({ram_en, ram_we, p0_ack, p1_ack} !== 4'b0) begin n_fail++; $display("FAIL reset_strobes got %b exp 0000", {ram_en, ram_we, p0_ack, p1_ack}); end
    n_chk++; if ({ram_addr, ram_wdata, p0_rdata, p1_rdata} !== '0) begin n_fail++; $display("FAIL reset_buses got %h exp 0", {ram_addr, ram_wdata, p0_rdata, p1_rdata}); end
    rst_n = 1;
  endtask

  task automatic test_load();
    mem[5] = 32'h12345678;
    p0_req = 1; p0_we = 0; p0_addr = 6'h05;
    tick();
    n_chk++; if ({busy, ram_en, ram_we} !== 3'b110) begin n_fail++; $display("FAIL load_access_strobes got %b exp 110", {busy, ram_en, ram_we}); end
    n_chk++; if (ram_addr !== 6'h05) begin n_fail++; $display("FAIL load_ram_addr got %h exp 05", ram_addr); end
    n_chk++; if (p0_ack !== 1'b0) begin n_fail++; $display("FAIL load_early_ack got %b exp 0", p0_ack); end
    tick();
    n_chk++; if ({p0_ack, p1_ack, ram_en} !== 3'b100) begin n_fail++; $display("FAIL load_done_acks got %b exp 100", {p0_ack, p1_ack, ram_en}); end
    n_chk++; if (p0_rdata !== 32'h12345678) begin n_fail++; $display("FAIL load_rdata got %h exp 12345678", p0_rdata); end
    p0_req = 0;
    tick();
    n_chk++; if ({busy, p0_ack} !== 2'b00) begin n_fail++; $display("FAIL load_back_idle got %b exp 00", {busy, p0_ack}); end
    n_chk++; if (p0_rdata !== '0) begin n_fail++; $display("FAIL load_rdata_after got %h exp 0", p0_rdata); end
  endtask

  task automatic test_store();
    mem[63] = 32'h0;
    p1_req = 1; p1_we = 1; p1_addr = 6'h3F; p1_wdata = 32'hDEADBEEF;
    tick();
    n_chk++; if ({ram_en, ram_we} !== 2'b11) begin n_fail++; $display("FAIL store_strobes got %b exp 11", {ram_en, ram_we}); end
    n_chk++; if ({ram_addr, ram_wdata} !== {6'h3F, 32'hDEADBEEF}) begin n_fail++; $display("FAIL store_bus got %h/%h exp 3f/deadbeef", ram_addr, ram_wdata); end
    tick();
    n_chk++; if ({p1_ack, p0_ack, ram_en, ram_we} !== 4'b1000) begin n_fail++; $display("FAIL store_ack got %b exp 1000", {p1_ack, p0_ack, ram_en, ram_we}); end
    n_chk++; if (p1_rdata !== '0) begin n_fail++; $display("FAIL store_rdata got %h exp 0", p1_rdata); end
    n_chk++; if ({ram_addr, ram_wdata} !== '0) begin n_fail++; $display("FAIL store_bus_idle got %h exp 0", {ram_addr, ram_wdata}); end
    n_chk++; if (mem[63] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_mem got %h exp deadbeef", mem[63]); end
    p1_req = 0; p1_we = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    rst_n = 0;
    p0_req = 1; p0_we = 0; p0_addr = 6'h01;
    p1_req = 1; p1_we = 0; p1_addr = 6'h02;
    tick();
    rst_n = 1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      n_chk++;
      if ({p0_ack, p1_ack} !== {(i == 2 || i == 8), (i == 5 || i == 11)}) begin
        n_fail++; $display("FAIL rr_cycle%0d acks got %b exp %b", i, {p0_ack, p1_ack}, {(i == 2 || i == 8), (i == 5 || i == 11)});
      end
    end
    p0_req = 0; p1_req = 0;
    tick(); tick();
  endtask

  task automatic test_addr_change();
    mem[1] = 32'hA1A1A1A1; mem[2] = 32'hB2B2B2B2;
    p0_req = 1; p0_we = 0; p0_addr = 6'h01;
    tick();
    p0_addr = 6'h02; p0_we = 1; p0_wdata = 32'h55555555;
    #1;
    n_chk++; if ({ram_addr, ram_we} !== {6'h01, 1'b0}) begin n_fail++; $display("FAIL chg_ram_addr got %h/%b exp 01/0", ram_addr, ram_we); end
    tick();
    n_chk++; if ({p0_ack, p0_rdata} !== {1'b1, 32'hA1A1A1A1}) begin n_fail++; $display("FAIL chg_rdata got %b/%h exp 1/a1a1a1a1", p0_ack, p0_rdata); end
    n_chk++; if (mem[2] !== 32'hB2B2B2B2) begin n_fail++; $display("FAIL chg_mem2 got %h exp b2b2b2b2", mem[2]); end
    p0_req = 0; p0_we = 0;
    tick();
  endtask

  task automatic test_drop_early();
    mem[9] = 32'h0BADF00D;
    p0_req = 1; p0_we = 0; p0_addr = 6'h09;
    tick();
    p0_req = 0;
    tick();
    n_chk++; if ({p0_ack, p0_rdata} !== {1'b1, 32'h0BADF00D}) begin n_fail++; $display("FAIL drop_ack got %b/%h exp 1/0badf00d", p0_ack, p0_rdata); end
    tick();
  endtask

  task automatic test_reset_abort();
    mem[16] = 32'h11112222;
    p1_req = 1; p1_we = 1; p1_addr = 6'h10; p1_wdata = 32'hCAFEF00D;
    tick();
    n_chk++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL abort_pre_we got %b exp 1", ram_we); end
    rst_n = 0;
    #1;
    n_chk++; if ({ram_en, ram_we, busy} !== 3'b000) begin n_fail++; $display("FAIL abort_strobes got %b exp 000", {ram_en, ram_we, busy}); end
    tick();
    p1_req = 0; p1_we = 0;
    rst_n = 1;
    n_chk++; if (mem[16] !== 32'h11112222) begin n_fail++; $display("FAIL abort_mem got %h exp 11112222", mem[16]); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if ({p1_ack, busy} !== 2'b00) begin n_fail++; $display("FAIL abort_no_ack%0d got %b exp 00", i, {p1_ack, busy}); end
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_chk++; if ({busy, ram_en, p0_ack, p1_ack} !== 4'b0) begin n_fail++; $display("FAIL idle%0d got %b exp 0000", i, {busy, ram_en, p0_ack, p1_ack}); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_addr_change();
    test_drop_early();
    test_reset_abort();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
